mux_nx1_reg: RTL
================

Name: mux_nx1_reg

Overview:
- Registered N-to-1 operand selector with valid/ready handshake; successor to the combinational 2:1 operand mux in the calculator datapath.
- Chooses one of NUM_CH operand channels in one of two modes:
  - fixed mode: the Sel port picks the channel.
  - auto mode: a round-robin arbiter picks the channel.
- Registers the chosen operand toward the ALU operand stage.
- Full throughput: one transfer per cycle under continuous valid/ready.

Parameters:
WIDTH, 8, data width of every channel and of Out
NUM_CH, 4, number of input channels (2..16)
SEL_W, 2, width of Sel and Out_Ch; must satisfy 2^SEL_W >= NUM_CH

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Auto  input  1  0 = fixed select via Sel, 1 = round-robin over valid channels
Sel  input  SEL_W  channel index in fixed mode; ignored when Auto=1
In_Data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
In_Valid  input  NUM_CH  per-channel valid
In_Ready  output  NUM_CH  per-channel ready; at most one bit high per cycle
Out  output  WIDTH  registered selected operand
Out_Valid  output  1  Out holds an unconsumed operand
Out_Ready  input  1  downstream accepts Out
Out_Ch  output  SEL_W  index of the channel that produced Out
Sel_Err  output  1  sticky flag: fixed mode with Sel >= NUM_CH while any In_Valid is high

Behaviour:
- Interface: one clock Clk; reset Rst_n is asynchronous, active-low.
- Reset values: Out=0, Out_Valid=0, Out_Ch=0, Sel_Err=0, round-robin pointer=0.
- In_Ready is combinational and is 0 while Rst_n is low.
- Output register is free when (!Out_Valid || Out_Ready).
- Grant, combinational, evaluated each cycle:
  - Fixed mode (Auto=0): grant channel g=Sel if Sel < NUM_CH, the register is free, and In_Valid[Sel]=1.
  - Auto mode (Auto=1): search for the first k with In_Valid[k]=1, starting at pointer p and wrapping modulo NUM_CH through p+NUM_CH-1. Grant that k if the register is free.
  - In_Ready[g]=1 only for the granted channel. All other In_Ready bits are 0. With no grant, all In_Ready bits are 0.
- Transfer on In_Valid[g] && In_Ready[g]:
  - Next edge: Out <= channel g data, Out_Ch <= g, Out_Valid <= 1.
  - Latency: exactly 1 cycle from input handshake to Out_Valid.
- Pointer update: in auto mode, a transfer sets p <= (g+1) mod NUM_CH. Wrap: g=NUM_CH-1 gives p=0. Fixed-mode transfers leave p unchanged.
- Output consumption: Out_Valid && Out_Ready with no new transfer gives Out_Valid <= 0 next edge. Out and Out_Ch hold their last values.
- Simultaneous pop and push in the same cycle: Out_Valid stays 1 and Out loads the new data. No bubble.
- Stall: Out_Valid=1 and Out_Ready=0 means Out, Out_Ch and Out_Valid hold, and all In_Ready bits are 0.
- Mode switch: Auto and Sel are sampled every cycle. A change affects only the next grant, never a registered word.
- Sel out of range (fixed mode, Sel >= NUM_CH): no grant. If any In_Valid bit is high, Sel_Err <= 1 and stays 1 until reset.
- Reset mid-operation: Rst_n low clears all state immediately, without waiting for Clk. Any pending Out word is discarded.
- NUM_CH not a power of two: indices NUM_CH..2^SEL_W-1 are never granted. The pointer never takes those values.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Adds output port Out_Par (1 bit), registered in the same cycle as Out.
  - Out_Par equals the XOR of the loaded data, i.e. even parity over Out.
  - Reset value 0. Holds along with Out.
- Not defined: port Out_Par does not exist and no parity logic is built.

Test Plan:
1. Reset, then Auto=0, Sel=2, In_Valid=4'b0100, ch2=8'hA5, Out_Ready=1 -> In_Ready=4'b0100; next cycle Out=8'hA5, Out_Ch=2, Out_Valid=1.
2. Auto=1, In_Valid=4'b1111 held, channels 8'h10/11/12/13, Out_Ready=1 -> Out sequence 10,11,12,13,10 on consecutive cycles with no bubble; pointer wraps 3->0.
3. Auto=1, In_Valid=4'b1001, pointer=1 -> ch3 granted first, then ch0, then ch3.
4. Out_Valid=1, Out_Ready=0 for 3 cycles with ch1 valid -> Out holds; In_Ready=0; ch1 transfers on the cycle Out_Ready returns to 1, and Out updates on the next edge.
5. NUM_CH=3, SEL_W=2, Auto=0, Sel=3, In_Valid=3'b111 -> no In_Ready bit high; Sel_Err=1 next cycle and stays 1 after Sel=0; cleared only by Rst_n.
6. Rst_n asserted low mid-stream with Out_Valid=1 -> Out_Valid=0, Out=0, Out_Ch=0 immediately, without a clock edge. With MUX_PARITY_EN and data 8'h07 -> Out_Par=1; with 8'h03 -> Out_Par=0.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: registered N-to-1 operand selector with a valid/ready handshake.
// One of NUM_CH operand channels is chosen each cycle, either by the Sel port
// (Auto=0) or by a round-robin arbiter over the valid channels (Auto=1). The
// chosen word lands in a single output register that feeds the ALU operand
// stage. A simultaneous pop and push keeps the register full, so continuous
// valid/ready gives one transfer per cycle.
// Optional build macro MUX_PARITY_EN adds a registered even-parity bit Out_Par.
module mux_nx1_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Auto,
  input  logic [SEL_W-1:0]        Sel,
  input  logic [NUM_CH*WIDTH-1:0] In_Data,
  input  logic [NUM_CH-1:0]       In_Valid,
  output logic [NUM_CH-1:0]       In_Ready,
  output logic [WIDTH-1:0]        Out,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [SEL_W-1:0]        Out_Ch,
  output logic                    Sel_Err
`ifdef MUX_PARITY_EN
  ,
  output logic                    Out_Par
`endif
);

  // Valid vector padded to a power of two so that an index one bit wider than
  // Sel can address it directly; the padding bits are never valid.
  localparam int               PAD_W    = 1 << (SEL_W + 1);
  localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE_CH   = SEL_W'(1);

`ifdef MUX_PARITY_EN
  // Even parity over a data word: the XOR of all its bits.
  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  logic [PAD_W-1:0]  valid_pad_s;
  logic              free_s;
  logic              sel_ok_s;
  logic              fixed_hit_s;
  logic              auto_hit_s;
  logic [SEL_W-1:0]  auto_ch_s;
  logic [SEL_W:0]    auto_idx_s;
  logic              grant_s;
  logic [SEL_W-1:0]  grant_ch_s;
  logic [WIDTH-1:0]  data_sel_s;
  logic              sel_err_set_s;

  logic [WIDTH-1:0]  out_r;
  logic              out_valid_r;
  logic [SEL_W-1:0]  out_ch_r;
  logic              sel_err_r;
  logic [SEL_W-1:0]  ptr_r;

  assign valid_pad_s = {{(PAD_W - NUM_CH){1'b0}}, In_Valid};

  // The output register may accept a word when it is empty or being drained.
  assign free_s = !out_valid_r || Out_Ready;

  // Fixed-mode selection: only in-range indices can ever be granted.
  always_comb begin
    sel_ok_s      = ({1'b0, Sel} < NUM_CH_L);
    fixed_hit_s   = sel_ok_s && valid_pad_s[{1'b0, Sel}];
    sel_err_set_s = !Auto && !sel_ok_s && (|In_Valid);
  end

  // Round-robin search: first valid channel at or after the pointer, wrapping
  // modulo NUM_CH so indices NUM_CH..2^SEL_W-1 are never visited.
  always_comb begin
    auto_hit_s = 1'b0;
    auto_ch_s  = '0;
    auto_idx_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      auto_idx_s = {1'b0, ptr_r} + (SEL_W + 1)'(i);
      if (auto_idx_s >= NUM_CH_L) begin
        auto_idx_s = auto_idx_s - NUM_CH_L;
      end else begin
        auto_idx_s = auto_idx_s;
      end
      if (!auto_hit_s && valid_pad_s[auto_idx_s]) begin
        auto_hit_s = 1'b1;
        auto_ch_s  = auto_idx_s[SEL_W-1:0];
      end else begin
        auto_hit_s = auto_hit_s;
        auto_ch_s  = auto_ch_s;
      end
    end
  end

  // Grant: pick the mode's candidate, and only when the register is free.
  always_comb begin
    if (Auto) begin
      grant_s    = free_s && auto_hit_s;
      grant_ch_s = auto_ch_s;
    end else begin
      grant_s    = free_s && fixed_hit_s;
      grant_ch_s = Sel;
    end
  end

  // One-hot ready toward the granted channel, forced low while in reset.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ready
    assign In_Ready[k] = Rst_n && grant_s && (grant_ch_s == SEL_W'(k));
  end

  // Data mux: route the granted channel's word to the output register input.
  always_comb begin
    data_sel_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch_s == SEL_W'(k)) begin
        data_sel_s = In_Data[k*WIDTH +: WIDTH];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  // Output data and source index: load on a transfer, otherwise hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_r    <= '0;
      out_ch_r <= '0;
    end else if (grant_s) begin
      out_r    <= data_sel_s;
      out_ch_r <= grant_ch_s;
    end
  end

  // Occupancy: set by a transfer, cleared by a pop that has no refill.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_r <= 1'b0;
    end else if (grant_s) begin
      out_valid_r <= 1'b1;
    end else if (Out_Ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer: moves past the winner only on auto-mode transfers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_r <= '0;
    end else if (grant_s && Auto) begin
      if (grant_ch_s == LAST_CH) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= grant_ch_s + ONE_CH;
      end
    end
  end

  // Sticky out-of-range select flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sel_err_r <= 1'b0;
    end else if (sel_err_set_s) begin
      sel_err_r <= 1'b1;
    end
  end

`ifdef MUX_PARITY_EN
  logic out_par_r;

  // Parity bit registered alongside the data word it protects.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_par_r <= 1'b0;
    end else if (grant_s) begin
      out_par_r <= even_parity(data_sel_s);
    end
  end

  assign Out_Par = out_par_r;
`endif

  assign Out       = out_r;
  assign Out_Valid = out_valid_r;
  assign Out_Ch    = out_ch_r;
  assign Sel_Err   = sel_err_r;

endmodule
